legv8_multicycle_control: RTL

Multicycle control sequencer for the ARM-LP LEGv8 datapath. It steps each instruction through fetch, decode, execute, memory and writeback. In each phase it drives the register-file write enable, the ALU source mux, the operand-register select, memory strobes and PC update into the operation-prep, ALU and memory stages. Memory phases stall on a ready handshake. Unsupported opcodes halt the core. A retired-instruction counter is exported for bring-up.

---
 rtl/legv8_multicycle_control_if.sv | 34 +++
 rtl/legv8_multicycle_control.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/legv8_multicycle_control_if.sv
// Control bundle between the LEGv8 multicycle sequencer and its datapath.
// The master modport is the sequencer; the slave modport is the datapath side.
interface legv8_multicycle_control_if;
  logic        run;
  logic [10:0] opcode;
  logic        zero;
  logic        memReady;

  logic        instrRead;
  logic        irWrite;
  logic        pcWrite;
  logic        pcSrc;
  logic        reg2Loc;
  logic        aluSRC;
  logic [1:0]  aluOp;
  logic        dataRead;
  logic        dataWrite;
  logic        memToReg;
  logic        regWrite;
  logic        halted;
  logic [31:0] retired;

  modport master (
    input  run, opcode, zero, memReady,
    output instrRead, irWrite, pcWrite, pcSrc, reg2Loc, aluSRC, aluOp,
           dataRead, dataWrite, memToReg, regWrite, halted, retired
  );

  modport slave (
    output run, opcode, zero, memReady,
    input  instrRead, irWrite, pcWrite, pcSrc, reg2Loc, aluSRC, aluOp,
           dataRead, dataWrite, memToReg, regWrite, halted, retired
  );
endinterface

// File: rtl/legv8_multicycle_control.sv
// Multicycle LEGv8 control sequencer: fetch/decode/execute/memory/writeback
// with memory-ready stalls, illegal-opcode halt and a retired-instruction counter.
module legv8_multicycle_control (
  input  logic clock,
  input  logic reset_n,
  legv8_multicycle_control_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXECUTE,
    MEMORY,
    WRITEBACK,
    HALT
  } state_t;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_I,
    CLS_LDUR,
    CLS_STUR,
    CLS_CBZ,
    CLS_B,
    CLS_ILL
  } instr_class_t;

  state_t       state;
  state_t       state_next;
  instr_class_t cls_q;
  instr_class_t cls_dec;
  logic         retire;
  logic [31:0]  retire_count;

  always_comb begin
    cls_dec = CLS_ILL;
    casez (bus.opcode)
      11'b10001011000,
      11'b11001011000,
      11'b10001010000,
      11'b10101010000: cls_dec = CLS_R;
      11'b1001000100?: cls_dec = CLS_I;
      11'b11111000010: cls_dec = CLS_LDUR;
      11'b11111000000: cls_dec = CLS_STUR;
      11'b10110100???: cls_dec = CLS_CBZ;
      11'b000101?????: cls_dec = CLS_B;
      default:         cls_dec = CLS_ILL;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The class is captured once in DECODE so later phases ignore IR-side glitches.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cls_q <= CLS_ILL;
    end else if (state == DECODE) begin
      cls_q <= cls_dec;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      retire_count <= 32'd0;
    end else if (retire) begin
      retire_count <= retire_count + 32'd1;
    end
  end

  assign bus.retired = retire_count;

  always_comb begin
    state_next    = state;
    retire        = 1'b0;
    bus.instrRead = 1'b0;
    bus.irWrite   = 1'b0;
    bus.pcWrite   = 1'b0;
    bus.pcSrc     = 1'b0;
    bus.reg2Loc   = 1'b0;
    bus.aluSRC    = 1'b0;
    bus.aluOp     = 2'b00;
    bus.dataRead  = 1'b0;
    bus.dataWrite = 1'b0;
    bus.memToReg  = 1'b0;
    bus.regWrite  = 1'b0;
    bus.halted    = 1'b0;

    unique case (state)
      IDLE: begin
        if (bus.run) state_next = FETCH;
      end

      FETCH: begin
        bus.instrRead = 1'b1;
        if (bus.memReady) begin
          bus.irWrite = 1'b1;
          bus.pcWrite = 1'b1;
          state_next  = DECODE;
        end
      end

      DECODE: begin
        bus.reg2Loc = (cls_dec == CLS_STUR) || (cls_dec == CLS_CBZ);
        state_next  = (cls_dec == CLS_ILL) ? HALT : EXECUTE;
      end

      EXECUTE: begin
        bus.reg2Loc = (cls_q == CLS_STUR) || (cls_q == CLS_CBZ);
        unique case (cls_q)
          CLS_LDUR, CLS_STUR: begin
            bus.aluSRC = 1'b1;
            state_next = MEMORY;
          end
          CLS_I: begin
            bus.aluSRC = 1'b1;
            state_next = WRITEBACK;
          end
          CLS_R: begin
            bus.aluOp  = 2'b10;
            state_next = WRITEBACK;
          end
          CLS_CBZ: begin
            bus.aluOp   = 2'b01;
            bus.pcSrc   = 1'b1;
            bus.pcWrite = bus.zero;
            retire      = 1'b1;
            state_next  = bus.run ? FETCH : IDLE;
          end
          CLS_B: begin
            bus.pcSrc   = 1'b1;
            bus.pcWrite = 1'b1;
            retire      = 1'b1;
            state_next  = bus.run ? FETCH : IDLE;
          end
          default: state_next = HALT;
        endcase
      end

      MEMORY: begin
        bus.dataRead  = (cls_q == CLS_LDUR);
        bus.dataWrite = (cls_q == CLS_STUR);
        if (bus.memReady) begin
          if (cls_q == CLS_LDUR) begin
            state_next = WRITEBACK;
          end else begin
            retire     = 1'b1;
            state_next = bus.run ? FETCH : IDLE;
          end
        end
      end

      WRITEBACK: begin
        bus.regWrite = 1'b1;
        bus.memToReg = (cls_q == CLS_LDUR);
        retire       = 1'b1;
        state_next   = bus.run ? FETCH : IDLE;
      end

      HALT: begin
        bus.halted = 1'b1;
      end

      default: state_next = IDLE;
    endcase
  end

  // The PC and register file must never be written in the same cycle.
  assert property (@(posedge clock) disable iff (!reset_n) !(bus.pcWrite && bus.regWrite));

endmodule
